// File: rtl/mmio_console_tx.sv
// mmio_console_tx
//   Memory-mapped console transmitter on the processor data-memory port.
//   Stores to TXDATA push a byte into an output FIFO that a downstream
//   sink drains over valid/ready. The block also exposes STATUS, a
//   free-running cycle counter and, optionally, a dropped-push counter.
//
//   Register window (16 bytes at BASE_ADDR, word index = addr[28:29]):
//     idx0 TXDATA  write pushes data_in[24:31]; reads 0
//     idx1 STATUS  [16:23]=count [29]=overflow (W1C) [30]=full [31]=empty
//     idx2 CYCLES  free-running; a word write loads it
//     idx3 OVFCNT  dropped-push count (saturating); a word write clears it
//
//   Optional feature macro: CONSOLE_OVFCNT_EN
//     defined   -> OVFCNT counter present
//     undefined -> idx3 reads 0, writes are ignored
//
//   Ports (bit 0 is the MSB of every vector):
//     clock, reset            system clock, asynchronous active-high reset
//     addr, data_in           processor byte address and store data
//     write_enable            store strobe
//     mem_byte, mem_half_word access size (neither set = word)
//     sign_extend             sign-extend narrow reads
//     hit, data_out           window decode and read data (combinational)
//     tx_valid, tx_data       FIFO head towards the sink
//     tx_ready                sink accepts the head this cycle
module mmio_console_tx #(
    parameter logic [0:31] BASE_ADDR = 32'hFFFF0000,
    parameter int          DEPTH     = 16,
    parameter int          PTR_W     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] addr,
    input  logic [0:31] data_in,
    input  logic        write_enable,
    input  logic        mem_byte,
    input  logic        mem_half_word,
    input  logic        sign_extend,
    output logic        hit,
    output logic [0:31] data_out,
    output logic        tx_valid,
    output logic [0:7]  tx_data,
    input  logic        tx_ready
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [0:7]       mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic [0:31]      cycles;
    logic [0:31]      ovfcnt_rd;

    logic [1:0]  idx;
    logic        is_word;
    logic        full;
    logic        empty;
    logic        txdata_wr;
    logic        push;
    logic        drop;
    logic        pop;
    logic        status_clr;
    logic        cycles_ld;
    logic [0:7]  count8;
    logic [0:31] status;
    logic [0:31] reg_val;

    // Byte offset within a word does not select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[30:31];

    assign hit     = (addr[0:27] == BASE_ADDR[0:27]);
    assign idx     = addr[28:29];
    assign is_word = !mem_byte && !mem_half_word;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A push into a full FIFO is dropped even if the sink pops on the same
    // edge: "full" is the state before the edge.
    assign txdata_wr  = hit && write_enable && (idx == 2'd0);
    assign push       = txdata_wr && !full;
    assign drop       = txdata_wr && full;
    assign pop        = tx_valid && tx_ready;
    assign status_clr = hit && write_enable && (idx == 2'd1) && data_in[29];
    assign cycles_ld  = hit && write_enable && (idx == 2'd2) && is_word;

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : mem[rd_ptr];

    // FIFO storage is pure data and carries no reset; emptiness is tracked
    // by count, which gates tx_data.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_in[24:31];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cycles   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A new drop wins over a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (status_clr) begin
                overflow <= 1'b0;
            end
            if (cycles_ld) begin
                cycles <= data_in;
            end else begin
                cycles <= cycles + 32'd1;
            end
        end
    end

`ifdef CONSOLE_OVFCNT_EN
    logic [0:31] ovfcnt;
    logic        ovfcnt_clr;

    assign ovfcnt_clr = hit && write_enable && (idx == 2'd3) && is_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovfcnt <= '0;
        end else if (ovfcnt_clr) begin
            ovfcnt <= '0;
        end else if (drop && (ovfcnt != 32'hFFFFFFFF)) begin
            ovfcnt <= ovfcnt + 32'd1;
        end
    end

    assign ovfcnt_rd = ovfcnt;
`else
    assign ovfcnt_rd = '0;
`endif

    assign count8 = 8'(count);
    assign status = {16'h0000, count8, 5'b00000, overflow, full, empty};

    always_comb begin
        reg_val = '0;
        case (idx)
            2'd0:    reg_val = '0;
            2'd1:    reg_val = status;
            2'd2:    reg_val = cycles;
            default: reg_val = ovfcnt_rd;
        endcase
    end

    // Narrow reads take the low-order byte/halfword of the register.
    always_comb begin
        data_out = '0;
        if (hit) begin
            if (mem_byte) begin
                data_out = {{24{sign_extend & reg_val[24]}}, reg_val[24:31]};
            end else if (mem_half_word) begin
                data_out = {{16{sign_extend & reg_val[16]}}, reg_val[16:31]};
            end else begin
                data_out = reg_val;
            end
        end
    end

endmodule
